// File: rtl/rambam_sbox_sequencer.sv
// -----------------------------------------------------------------------------
// rambam_sbox_sequencer
//
// Drives the masked RAMBAM S-box inversion t254 = t1^254 through one shared
// external operator unit, so that each cycle handles one intermediate.
// The chain below uses one operation per step; step k consumes randomness
// word k-1:
//   1: t2   = pow2(t1)        2: t3   = mul(t2, t1)
//   3: t12  = pow4(t3)        4: t15  = mul(t12, t3)
//   5: t14  = mul(t12, t2)    6: t240 = pow16(t15)
//   7: t254 = mul(t240, t14)
// The sequencer does no arithmetic. It only sequences operands and captures
// the results.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_data  masked input element t1 (W = 8+D bits)
//   out_valid/out_ready/out_data  masked result t254
//   rnd_valid/rnd_ready/rnd_data  fresh D-bit refresh randomness
//   op_valid/op_code/op_a/op_b/op_rnd  issue port to the operator unit
//                              (0 mul, 1 pow2, 2 pow4, 3 pow16)
//   op_res                     operator result, valid MUL_LAT cycles after issue
//   busy                       high whenever not IDLE
// -----------------------------------------------------------------------------
module rambam_sbox_sequencer #(
  parameter int D       = 8,
  parameter int MUL_LAT = 1,
  localparam int W      = 8 + D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  input  logic         rnd_valid,
  output logic         rnd_ready,
  input  logic [D-1:0] rnd_data,
  output logic         op_valid,
  output logic [1:0]   op_code,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic [D-1:0] op_rnd,
  input  logic [W-1:0] op_res,
  output logic         busy
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_next;
  logic [2:0]    step, step_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          latch_in;
  logic          capture;
  logic          done_load;

  // t_regs[0] = t1, t_regs[k] = result of step k (k = 1..6):
  // t1, t2, t3, t12, t15, t14, t240
  logic [W-1:0]  t_regs [0:6];
  logic [6:0]    wr_en;

  assign wr_en[0] = latch_in;

  genvar gi;
  generate
    for (gi = 1; gi < 7; gi++) begin : g_wr_en
      assign wr_en[gi] = capture && (step == 3'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      step     <= '0;
      cnt      <= '0;
      out_data <= '0;
      for (int k = 0; k < 7; k++) t_regs[k] <= '0;
    end else begin
      state <= state_next;
      step  <= step_next;
      cnt   <= cnt_next;
      if (done_load) out_data <= op_res;
      for (int k = 0; k < 7; k++) begin
        if (wr_en[k]) t_regs[k] <= (k == 0) ? in_data : op_res;
      end
    end
  end

  always_comb begin
    state_next = state;
    step_next  = step;
    cnt_next   = cnt;
    latch_in   = 1'b0;
    capture    = 1'b0;
    done_load  = 1'b0;
    in_ready   = 1'b0;
    rnd_ready  = 1'b0;
    op_valid   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          latch_in   = 1'b1;
          step_next  = 3'd1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        // The issue strobe is the randomness handshake itself, so a stall
        // on rnd_valid simply holds the step in ISSUE.
        rnd_ready = 1'b1;
        op_valid  = rnd_valid;
        if (rnd_valid) begin
          cnt_next   = CW'(MUL_LAT - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture = 1'b1;
          if (step == 3'd7) begin
            done_load  = 1'b1;
            state_next = DONE;
          end else begin
            step_next  = step + 3'd1;
            state_next = ISSUE;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          step_next  = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands come only from registers and the step number, so they remain
  // stable through ISSUE stalls and the whole WAIT window.
  always_comb begin
    op_code = 2'd0;
    op_a    = '0;
    op_b    = '0;
    case (step)
      3'd1: begin op_code = 2'd1; op_a = t_regs[0]; end
      3'd2: begin op_code = 2'd0; op_a = t_regs[1]; op_b = t_regs[0]; end
      3'd3: begin op_code = 2'd2; op_a = t_regs[2]; end
      3'd4: begin op_code = 2'd0; op_a = t_regs[3]; op_b = t_regs[2]; end
      3'd5: begin op_code = 2'd0; op_a = t_regs[3]; op_b = t_regs[1]; end
      3'd6: begin op_code = 2'd3; op_a = t_regs[4]; end
      3'd7: begin op_code = 2'd0; op_a = t_regs[6]; op_b = t_regs[5]; end
      default: ;
    endcase
  end

  assign op_rnd    = rnd_data;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule
